// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and helpers for the multi-port register file with busy scoreboard.
package regfile_mp_sb_pkg;

  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_NREGS   = 32;
  localparam int unsigned DEF_NRD     = 2;
  localparam int unsigned DEF_ZERO_R0 = 1;
  localparam int unsigned DEF_BYPASS  = 1;

  function automatic int unsigned addr_width(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, reserve wins on collision.
module regfile_mp_sb_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned NREGS   = DEF_NREGS,
  parameter int unsigned ZERO_R0 = DEF_ZERO_R0,
  localparam int unsigned AW     = addr_width(NREGS),
  localparam int unsigned CW     = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic [CW-1:0]    busy_cnt
);

  logic             zero_mask;
  logic             wr_eff;
  logic             rsv_eff;
  logic             set_new;
  logic             clr_old;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;

  assign zero_mask = (ZERO_R0 != 0);

  // Filter out register-0 traffic and work out whether the population count moves.
  always_comb begin
    busy_nxt = busy_vec;
    wr_eff   = wr_en  && !(zero_mask && (wr_addr  == '0));
    rsv_eff  = rsv_en && !(zero_mask && (rsv_addr == '0));
    set_new  = rsv_eff && !busy_vec[rsv_addr];
    clr_old  = wr_eff && busy_vec[wr_addr] && !(rsv_eff && (rsv_addr == wr_addr));
    if (wr_eff)  busy_nxt[wr_addr]  = 1'b0;
    if (rsv_eff) busy_nxt[rsv_addr] = 1'b1;
    cnt_nxt  = busy_cnt + CW'(set_new) - CW'(clr_old);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised register file: NRD combinational read ports, one write port,
// optional write->read bypass, optional hardwired r0, busy scoreboard.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned NREGS   = DEF_NREGS,
  parameter int unsigned NRD     = DEF_NRD,
  parameter int unsigned ZERO_R0 = DEF_ZERO_R0,
  parameter int unsigned BYPASS  = DEF_BYPASS,
  localparam int unsigned AW     = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [AW:0]       busy_cnt,
  output logic [NREGS-1:0]  busy_vec
);

  logic [DW-1:0] rf [NREGS];
  logic          wr_ok;

  assign wr_ok = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wr_addr] <= wr_data;
    end
  end

  regfile_mp_sb_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zhit;
    logic          byp;

    assign ra   = rd_addr[k*AW +: AW];
    assign zhit = (ZERO_R0 != 0) && (ra == '0);
    // Bypass never overrides the zero register; busy is never bypassed.
    assign byp  = (BYPASS != 0) && wr_en && (ra == wr_addr);

    assign rd_data[k*DW +: DW] = zhit ? '0 : (byp ? wr_data : rf[ra]);
    assign rd_busy[k]          = zhit ? 1'b0 : busy_vec[ra];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default parameters) against an array/count model.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [AW:0]       busy_cnt;
  logic [NR-1:0]     busy_vec;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mrf [NR];
  bit            mbusy [NR];

  regfile_mp_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) if (mbusy[i]) c++;
    return c;
  endfunction

  function automatic logic [NR-1:0] model_vec();
    logic [NR-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] model_rd(input int a);
    if (a == 0) return '0;
    if (wr_en && a == int'(wr_addr)) return wr_data;
    return mrf[a];
  endfunction

  function automatic logic model_busy(input int a);
    return (a == 0) ? 1'b0 : logic'(mbusy[a]);
  endfunction

  // Architectural effect of the edge, from the currently driven inputs.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin mrf[i] = '0; mbusy[i] = 0; end
    end else begin
      if (wr_en && wr_addr != 0) begin mrf[wr_addr] = wr_data; mbusy[wr_addr] = 0; end
      if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; rsv_en = 0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); rst = 0;
    for (int a = 0; a < NR; a += 2) begin
      set_rd(a, a + 1); #1;
      checks++;
      if (rd_data !== '0) begin
        errors++; $display("FAIL reset_rd addr %0d got %h want 0", a, rd_data);
      end
    end
    checks++;
    if (busy_vec !== '0 || busy_cnt !== '0) begin
      errors++; $display("FAIL reset_sb got vec=%h cnt=%0d want 0/0", busy_vec, busy_cnt);
    end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(5, 6); #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_rd got %h want deadbeef", rd_data[31:0]);
    end
    tick(); idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== 32'h0) begin
      errors++; $display("FAIL write_rd got %h want 00000000deadbeef", rd_data);
    end
  endtask

  task automatic test_zero_reg();
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rsv_en = 1; rsv_addr = 0; set_rd(0, 0); #1;
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL r0_bypass got %h want 0", rd_data);
    end
    tick(); idle(); #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00 || busy_cnt !== 0) begin
      errors++; $display("FAIL r0 got rd=%h busy=%b cnt=%0d want 0/00/0", rd_data, rd_busy, busy_cnt);
    end
  endtask

  task automatic test_scoreboard();
    idle(); rsv_en = 1; rsv_addr = 3; tick(); rsv_addr = 7; tick(); idle(); #1;
    checks++;
    if (busy_cnt !== 2) begin
      errors++; $display("FAIL sb_two got %0d want 2", busy_cnt);
    end
    wr_en = 1; wr_addr = 3; wr_data = 32'h33; tick(); idle(); set_rd(3, 7); #1;
    checks++;
    if (busy_cnt !== 1 || rd_busy !== 2'b10) begin
      errors++; $display("FAIL sb_write got cnt=%0d busy=%b want 1/10", busy_cnt, rd_busy);
    end
    rsv_en = 1; rsv_addr = 7; tick(); idle(); #1;
    checks++;
    if (busy_cnt !== 1 || busy_vec !== 32'h0000_0080) begin
      errors++; $display("FAIL sb_rersv got cnt=%0d vec=%h want 1/00000080", busy_cnt, busy_vec);
    end
  endtask

  task automatic test_collision();
    int c0;
    idle(); rsv_en = 1; rsv_addr = 9; tick(); idle(); #1;
    c0 = model_cnt();
    wr_en = 1; wr_addr = 9; wr_data = 32'hAA; rsv_en = 1; rsv_addr = 9; tick(); idle(); set_rd(9, 4); #1;
    checks++;
    if (rd_data[31:0] !== 32'hAA || busy_vec[9] !== 1'b1 || int'(busy_cnt) != c0) begin
      errors++; $display("FAIL coll_same got rd=%h b9=%b cnt=%0d want aa/1/%0d",
                         rd_data[31:0], busy_vec[9], busy_cnt, c0);
    end
    wr_en = 1; wr_addr = 9; wr_data = 32'hBB; rsv_en = 1; rsv_addr = 4; tick(); idle(); #1;
    checks++;
    if (int'(busy_cnt) != c0 || rd_busy !== 2'b10 || rd_data[31:0] !== 32'hBB) begin
      errors++; $display("FAIL coll_diff got cnt=%0d busy=%b rd=%h want %0d/10/bb",
                         busy_cnt, rd_busy, rd_data[31:0], c0);
    end
  endtask

  task automatic test_random();
    int a0, a1;
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      wr_en    = $urandom_range(0, 1);
      wr_addr  = AW'($urandom_range(0, NR - 1));
      wr_data  = $urandom;
      rsv_en   = $urandom_range(0, 1);
      rsv_addr = (n % 5 == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      a0 = (n % 3 == 0) ? int'(wr_addr) : int'($urandom_range(0, NR - 1));
      a1 = $urandom_range(0, NR - 1);
      set_rd(a0, a1); #1;
      checks++;
      if (rd_data !== {model_rd(a1), model_rd(a0)} || rd_busy !== {model_busy(a1), model_busy(a0)}
          || busy_vec !== model_vec() || int'(busy_cnt) != model_cnt()) begin
        errors++;
        $display("FAIL rand n=%0d got rd=%h rb=%b vec=%h cnt=%0d want rd=%h rb=%b vec=%h cnt=%0d",
                 n, rd_data, rd_busy, busy_vec, busy_cnt, {model_rd(a1), model_rd(a0)},
                 {model_busy(a1), model_busy(a0)}, model_vec(), model_cnt());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); rst = 1; tick(); idle(); rsv_en = 1;
    for (int r = 1; r < NR; r++) begin rsv_addr = AW'(r); tick(); end
    idle(); #1;
    checks++;
    if (busy_cnt !== 31 || busy_vec !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL fill got cnt=%0d vec=%h want 31/fffffffe", busy_cnt, busy_vec);
    end
    rst = 1; wr_en = 1; wr_addr = 2; wr_data = 32'h5555; tick(); idle();
    for (int a = 0; a < NR; a += 2) begin
      set_rd(a, a + 1); #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00) begin
        errors++; $display("FAIL rst_mid addr %0d got rd=%h busy=%b want 0/00", a, rd_data, rd_busy);
      end
    end
    checks++;
    if (busy_cnt !== 0 || busy_vec !== '0) begin
      errors++; $display("FAIL rst_mid_sb got cnt=%0d vec=%h want 0/0", busy_cnt, busy_vec);
    end
  endtask

  initial begin
    idle(); set_rd(0, 0);
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
